alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// ALU operation sequencer: accepts an opcode, selects the target unit, waits for
// the single-cycle result or the multi-cycle muldiv handshake, registers the result
// and flags, and reports completion with a one-cycle done (and err) pulse.
module alu_sequencer #(
  parameter int unsigned data_wl    = 16,
  parameter int unsigned op_wl      = 8,
  parameter int unsigned md_timeout = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [op_wl-1:0]   op_in,
  output logic               ready,
  output logic [3:0]         active_vec,
  output logic [op_wl-1:0]   op_out,
  output logic               muldiv_start,
  input  logic               valid_in_muldiv,
  input  logic [data_wl-1:0] c_in,
  input  logic               z_in,
  input  logic               s_in,
  input  logic               c_flag_in,
  input  logic               ovr_in,
  output logic [data_wl-1:0] c_out,
  output logic               z_out,
  output logic               s_out,
  output logic               c_flag_out,
  output logic               ovr_out,
  output logic               done,
  output logic               err
);

  localparam int unsigned cnt_wl = $clog2(md_timeout + 1);

  typedef enum logic [1:0] {Idle, Exec, WaitMd, Done} state_t;

  state_t              state;
  logic [cnt_wl-1:0]   wait_cnt;
  // Set when the accepted opcode had the reserved bit; the EXEC cycle then selects
  // no unit and forces a zero result with err.
  logic                illegal;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= Idle;
      wait_cnt     <= '0;
      illegal      <= 1'b0;
      ready        <= 1'b1;
      active_vec   <= 4'b0000;
      op_out       <= '0;
      muldiv_start <= 1'b0;
      c_out        <= '0;
      z_out        <= 1'b0;
      s_out        <= 1'b0;
      c_flag_out   <= 1'b0;
      ovr_out      <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      done         <= 1'b0;
      err          <= 1'b0;
      muldiv_start <= 1'b0;
      case (state)
        Idle: begin
          if (start) begin
            op_out <= op_in;
            ready  <= 1'b0;
            if (op_in[5]) begin
              illegal    <= 1'b1;
              active_vec <= 4'b0000;
              state      <= Exec;
            end else if (op_in[7:6] == 2'b11) begin
              illegal      <= 1'b0;
              active_vec   <= 4'b1000;
              muldiv_start <= 1'b1;
              wait_cnt     <= '0;
              state        <= WaitMd;
            end else begin
              illegal    <= 1'b0;
              active_vec <= 4'b0001 << op_in[7:6];
              state      <= Exec;
            end
          end
        end
        Exec: begin
          active_vec <= 4'b0000;
          done       <= 1'b1;
          state      <= Done;
          if (illegal) begin
            err        <= 1'b1;
            c_out      <= '0;
            z_out      <= 1'b0;
            s_out      <= 1'b0;
            c_flag_out <= 1'b0;
            ovr_out    <= 1'b0;
          end else begin
            c_out      <= c_in;
            z_out      <= z_in;
            s_out      <= s_in;
            c_flag_out <= c_flag_in;
            ovr_out    <= ovr_in;
          end
        end
        WaitMd: begin
          // valid is ignored in the launch cycle; a valid on the last allowed
          // cycle still beats the timeout.
          if (valid_in_muldiv && (wait_cnt != '0)) begin
            c_out      <= c_in;
            z_out      <= z_in;
            s_out      <= s_in;
            c_flag_out <= c_flag_in;
            ovr_out    <= ovr_in;
            active_vec <= 4'b0000;
            done       <= 1'b1;
            state      <= Done;
          end else if (wait_cnt == cnt_wl'(md_timeout - 1)) begin
            active_vec <= 4'b0000;
            done       <= 1'b1;
            err        <= 1'b1;
            state      <= Done;
          end else begin
            wait_cnt <= wait_cnt + cnt_wl'(1);
          end
        end
        Done: begin
          wait_cnt <= '0;
          ready    <= 1'b1;
          state    <= Idle;
        end
        default: state <= Idle;
      endcase
    end
  end

endmodule
